// File: rtl/uart_loopback_display.sv
// uart_loopback_display: button-triggered 8N1 UART transmitter whose serial line is
// looped back into a receiver; the last good byte drives the LEDs and its low five
// bits are shown in decimal on two active-low 7-segment digits.
module uart_loopback_display #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [7:0] data,
  output logic       transmission,
  output logic [7:0] led_data,
  output logic [6:0] disp1,
  output logic [6:0] disp0
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // ---------------- transmitter ----------------
  state_t          tx_state, tx_state_nxt;
  logic            btn_q;
  logic [7:0]      tx_shift;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic            tx_go, tx_tick;

  assign tx_go   = btn_q & ~btn;
  assign tx_tick = (tx_cnt == LAST);

  // Previous button level, used to find the falling edge of a press.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn;
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_state_nxt;
  end

  // TX next state: presses are only accepted while idle, so edges mid-frame are dropped.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      IDLE:    if (tx_go) tx_state_nxt = START;
      START:   if (tx_tick) tx_state_nxt = DATA;
      DATA:    if (tx_tick && tx_bit == 3'd7) tx_state_nxt = STOP;
      STOP:    if (tx_tick) tx_state_nxt = IDLE;
      default: tx_state_nxt = IDLE;
    endcase
  end

  // TX bit-time and bit-index counters.
  always_ff @(posedge clk) begin
    if (rst || tx_state == IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_state == DATA) tx_bit <= tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // TX shift register: byte captured on the start cycle, shifted out LSB first.
  always_ff @(posedge clk) begin
    if (tx_state == IDLE && tx_go)       tx_shift <= data;
    else if (tx_state == DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Serial line level derived from the TX state; idle and stop are both high.
  always_comb begin
    transmission = 1'b1;
    case (tx_state)
      START:   transmission = 1'b0;
      DATA:    transmission = tx_shift[0];
      default: transmission = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  state_t          rx_state, rx_state_nxt;
  logic [7:0]      rx_shift;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic            rx_tick, rx_mid, line;

  assign line    = transmission;
  assign rx_tick = (rx_cnt == LAST);
  assign rx_mid  = (rx_cnt == HALF_LAST);

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_state_nxt;
  end

  // RX next state: with no half-bit wait the falling edge itself confirms the start bit.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      IDLE:    if (!line) rx_state_nxt = (HALF == 0) ? DATA : START;
      START:   if (line) rx_state_nxt = IDLE;
               else if (rx_mid) rx_state_nxt = DATA;
      DATA:    if (rx_tick && rx_bit == 3'd7) rx_state_nxt = STOP;
      STOP:    if (rx_tick) rx_state_nxt = IDLE;
      default: rx_state_nxt = IDLE;
    endcase
  end

  // RX counters: restart on every state change and at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst || rx_state == IDLE) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else if (rx_tick || rx_state != rx_state_nxt) begin
      rx_cnt <= '0;
      if (rx_state == DATA && rx_tick) rx_bit <= rx_bit + 3'd1;
    end else begin
      rx_cnt <= rx_cnt + CW'(1);
    end
  end

  // RX shift register: samples enter at the MSB so the first bit ends up in bit 0.
  always_ff @(posedge clk) begin
    if (rx_state == DATA && rx_tick) rx_shift <= {line, rx_shift[7:1]};
  end

  // LED register: only a frame with a valid stop bit updates it.
  always_ff @(posedge clk) begin
    if (rst) led_data <= '0;
    else if (rx_state == STOP && rx_tick && line) led_data <= rx_shift;
  end

  // ---------------- display ----------------
  logic [4:0] v;
  logic [3:0] tens, units;

  assign v     = led_data[4:0];
  assign tens  = 4'(v / 5'd10);
  assign units = 4'(v % 5'd10);

  // Decimal digits of the low five LED bits, leading zero kept.
  always_comb begin
    disp1 = seg7(tens);
    disp0 = seg7(units);
  end

endmodule

// File: tb/tb_uart_loopback_display.sv
// Testbench for uart_loopback_display: directed and random bytes through the loopback,
// checked against a frame/display model built from the 8N1 and decimal-digit rules.
module tb_uart_loopback_display;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [7:0] data;
  logic       transmission;
  logic [7:0] led_data;
  logic [6:0] disp1;
  logic [6:0] disp0;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_led;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  uart_loopback_display #(.CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .btn(btn), .data(data), .transmission(transmission),
    .led_data(led_data), .disp1(disp1), .disp0(disp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level i bit-times into the frame of byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return d[i-1];
  endfunction

  task automatic chk_display(input string tag, input logic [7:0] led);
    int v;
    v = led % 32;
    chk({tag, "_d1"}, 32'(disp1), 32'(seg_tab[v / 10]));
    chk({tag, "_d0"}, 32'(disp0), 32'(seg_tab[v % 10]));
  endtask

  // One-cycle press of byte d; called on a negedge, returns on the negedge after delivery.
  task automatic send(input logic [7:0] d);
    data = d;
    btn  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        btn  = 1'b1;
        data = 8'($urandom);
      end
      chk("line", 32'(transmission), 32'(frame_bit(d, i)));
      if (i == 9) chk("led_early", 32'(led_data), 32'(model_led));
    end
    @(negedge clk);
    model_led = d;
    chk("led", 32'(led_data), 32'(model_led));
    chk_display("disp", model_led);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b1; data = 8'h00; model_led = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_line", 32'(transmission), 32'd1);
    chk("rst_led", 32'(led_data), 32'd0);
    chk("rst_d1", 32'(disp1), 32'h40);
    chk("rst_d0", 32'(disp0), 32'h40);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_line", 32'(transmission), 32'd1);

    send(8'd20);
    chk("d20_d1", 32'(disp1), 32'b0100100);
    send(8'd44);
    chk("d44_d0", 32'(disp0), 32'b0100100);
    send(8'd66);
    send(8'd20);

    // Random bytes with random idle gaps, including back-to-back frames.
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom));
    end
    send(8'd31);
    send(8'd0);
    send(8'd9);

    // Button held low for 30 cycles: exactly one frame.
    begin
      logic [7:0] d;
      d = 8'($urandom);
      data = d;
      btn = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (i < 10) chk("hold_line", 32'(transmission), 32'(frame_bit(d, i)));
        else        chk("hold_idle", 32'(transmission), 32'd1);
        if (i == 10) begin
          model_led = d;
          chk("hold_led", 32'(led_data), 32'(model_led));
        end
      end
      btn = 1'b1;
      @(negedge clk);
    end

    // Second press in the middle of a frame is ignored.
    begin
      logic [7:0] d;
      d = 8'($urandom);
      data = d;
      btn = 1'b0;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i == 0) btn = 1'b1;
        if (i == 3) btn = 1'b0;
        if (i == 5) btn = 1'b1;
        if (i < 10) chk("mid_line", 32'(transmission), 32'(frame_bit(d, i)));
        else        chk("mid_idle", 32'(transmission), 32'd1);
        if (i == 10) begin
          model_led = d;
          chk("mid_led", 32'(led_data), 32'(model_led));
        end
      end
    end

    // Reset during the data bits aborts the frame.
    send(8'd27);
    begin
      data = 8'hA5;
      btn = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) btn = 1'b1;
        if (i == 4) rst = 1'b1;
      end
      @(negedge clk);
      model_led = 8'h00;
      chk("abort_line", 32'(transmission), 32'd1);
      chk("abort_led", 32'(led_data), 32'd0);
      chk_display("abort", model_led);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("abort_idle", 32'(transmission), 32'd1);
      end
      chk("abort_led2", 32'(led_data), 32'd0);
    end
    send(8'd20);
    send(8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
